// File: rtl/approx_comparator_pipe_if.sv
// approx_comparator_pipe_if
// Operand/result bundle for approx_comparator_pipe.
//   in_valid/in_ready      : operand beat handshake
//   A, B                   : operands (WIDTH bits)
//   signed_mode            : 1 = two's-complement compare, travels with the beat
//   approx_mode            : 1 = ignore the low APPROX_BITS, travels with the beat
//   out_valid/out_ready    : result handshake
//   EQ, GT, LT             : one-hot result flags while out_valid=1
//   ERR, err_count         : approx-vs-exact monitor (CMP_ERR_MON_EN builds only)
// Modports: slave = comparator side, master = producer/consumer side.
interface approx_comparator_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             signed_mode;
    logic             approx_mode;
    logic             out_valid;
    logic             out_ready;
    logic             EQ;
    logic             GT;
    logic             LT;
`ifdef CMP_ERR_MON_EN
    logic             ERR;
    logic [15:0]      err_count;
`endif

    modport slave (
        input  in_valid, A, B, signed_mode, approx_mode, out_ready,
        output in_ready, out_valid, EQ, GT, LT
`ifdef CMP_ERR_MON_EN
        , output ERR, err_count
`endif
    );

    modport master (
        output in_valid, A, B, signed_mode, approx_mode, out_ready,
        input  in_ready, out_valid, EQ, GT, LT
`ifdef CMP_ERR_MON_EN
        , input ERR, err_count
`endif
    );
endinterface

// File: rtl/approx_comparator_pipe.sv
// approx_comparator_pipe
// Two-stage pipelined magnitude comparator with optional LSB masking.
// Stage 1 registers per-chunk eq/gt vectors; stage 2 resolves them MSB-first
// into registered EQ/GT/LT flags. One beat per cycle, full backpressure.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : approx_comparator_pipe_if.slave (operands, modes, handshakes, flags)
// Optional feature macro: CMP_ERR_MON_EN -- adds a parallel exact compare and
// drives bus.ERR / bus.err_count (saturating mismatch counter).
module approx_comparator_pipe #(
    parameter int WIDTH       = 32,
    parameter int CHUNK       = 8,
    parameter int APPROX_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    approx_comparator_pipe_if.slave  bus
);
    localparam int N = WIDTH / CHUNK;
    localparam logic [WIDTH-1:0] MASK = {WIDTH{1'b1}} << APPROX_BITS;

    function automatic logic [N-1:0] f_chunk_eq(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = (a[i*CHUNK +: CHUNK] == b[i*CHUNK +: CHUNK]);
        return v;
    endfunction

    // Unsigned per chunk; the signed correction is applied in stage 2.
    function automatic logic [N-1:0] f_chunk_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = (a[i*CHUNK +: CHUNK] > b[i*CHUNK +: CHUNK]);
        return v;
    endfunction

    // Returns {eq, gt}. When the sign bits differ in signed mode, the top
    // chunk's unsigned verdict is exactly inverted (the MSB=1 operand is the
    // negative one), and the top chunk necessarily decides.
    function automatic logic [1:0] f_resolve(input logic [N-1:0] eqv, input logic [N-1:0] gtv,
                                             input logic flip);
        logic found;
        logic gt;
        found = 1'b0;
        gt    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!found && !eqv[i]) begin
                found = 1'b1;
                gt    = gtv[i] ^ ((i == N - 1) && flip);
            end
        end
        return {~found, gt};
    endfunction

    logic [WIDTH-1:0] w_a_m, w_b_m;
    logic             w_s1_load, w_s2_load;
    logic             w_flip;
    logic [1:0]       w_res;

    logic             r_s1_valid;
    logic [N-1:0]     r_s1_eq, r_s1_gt;
    logic             r_s1_signed;
    logic             r_s1_sdiff;
    logic             r_s2_valid;
    logic             r_eq, r_gt, r_lt;

    assign w_a_m     = bus.approx_mode ? (bus.A & MASK) : bus.A;
    assign w_b_m     = bus.approx_mode ? (bus.B & MASK) : bus.B;
    assign w_s2_load = !r_s2_valid || bus.out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign w_flip    = r_s1_signed && r_s1_sdiff;
    assign w_res     = f_resolve(r_s1_eq, r_s1_gt, w_flip);

    assign bus.in_ready  = w_s1_load && !rst;
    assign bus.out_valid = r_s2_valid;
    assign bus.EQ        = r_eq;
    assign bus.GT        = r_gt;
    assign bus.LT        = r_lt;

    // Masking never reaches the MSB, so the sign-difference bit is shared
    // between the approximate and exact paths.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid  <= bus.in_valid;
            r_s1_eq     <= f_chunk_eq(w_a_m, w_b_m);
            r_s1_gt     <= f_chunk_gt(w_a_m, w_b_m);
            r_s1_signed <= bus.signed_mode;
            r_s1_sdiff  <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
        end
    end

    // Flags are qualified by the valid bit so a bubble clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_eq       <= 1'b0;
            r_gt       <= 1'b0;
            r_lt       <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            r_eq       <= r_s1_valid &  w_res[1];
            r_gt       <= r_s1_valid & ~w_res[1] &  w_res[0];
            r_lt       <= r_s1_valid & ~w_res[1] & ~w_res[0];
        end
    end

`ifdef CMP_ERR_MON_EN
    logic [N-1:0] r_s1x_eq, r_s1x_gt;
    logic         r_s1_approx;
    logic [1:0]   w_res_x;
    logic         r_err;
    logic [15:0]  r_err_cnt;

    assign w_res_x       = f_resolve(r_s1x_eq, r_s1x_gt, w_flip);
    assign bus.ERR       = r_err;
    assign bus.err_count = r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_approx <= 1'b0;
        end else if (w_s1_load) begin
            r_s1x_eq    <= f_chunk_eq(bus.A, bus.B);
            r_s1x_gt    <= f_chunk_gt(bus.A, bus.B);
            r_s1_approx <= bus.approx_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err     <= 1'b0;
            r_err_cnt <= 16'h0000;
        end else begin
            if (w_s2_load)
                r_err <= r_s1_valid && r_s1_approx && (w_res != w_res_x);
            if (r_s2_valid && bus.out_ready && r_err && (r_err_cnt != 16'hFFFF))
                r_err_cnt <= r_err_cnt + 16'h0001;
        end
    end
`endif
endmodule

// File: tb/tb_approx_comparator_pipe.sv
module tb_approx_comparator_pipe;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic rand_ready;
    int   err_cnt_m;
    logic [3:0] q_exp[$];

    approx_comparator_pipe_if #(.WIDTH(32)) bus ();

    approx_comparator_pipe #(
        .WIDTH(32), .CHUNK(8), .APPROX_BITS(8)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: {eq, gt, lt, err} from plain integer compares.
    function automatic logic [3:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic s, input logic ap);
        logic [31:0] am, bm;
        logic [2:0]  fa, fx;
        am = ap ? {a[31:8], 8'h00} : a;
        bm = ap ? {b[31:8], 8'h00} : b;
        if (s) begin
            fa = {am == bm, $signed(am) > $signed(bm), $signed(am) < $signed(bm)};
            fx = {a == b, $signed(a) > $signed(b), $signed(a) < $signed(b)};
        end else begin
            fa = {am == bm, am > bm, am < bm};
            fx = {a == b, a > b, a < b};
        end
        return {fa, ap && (fa != fx)};
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input logic ap);
        int tries;
        tries = 0;
        @(negedge clk);
        bus.A = a; bus.B = b; bus.signed_mode = s; bus.approx_mode = ap;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready) begin
            tries++;
            if (tries > 200) begin
                check_val("send_timeout", 32'd1, 32'd0);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        q_exp.push_back(model(a, b, s, ap));
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q_exp.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", q_exp.size(), 32'd0);
    endtask

    // Scoreboard side: consumption happens at the next posedge.
    always @(negedge clk) begin
        logic [3:0] e;
        #2;
        if (bus.out_valid && bus.out_ready) begin
            if (q_exp.size() == 0) begin
                check_val("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = q_exp.pop_front();
                check_val("flags", {bus.EQ, bus.GT, bus.LT}, e[3:1]);
`ifdef CMP_ERR_MON_EN
                check_val("err", bus.ERR, e[0]);
                check_val("err_count", bus.err_count, err_cnt_m);
                if (e[0] && err_cnt_m < 32'hFFFF) err_cnt_m++;
`endif
            end
        end else if (!bus.out_valid) begin
            check_val("idle_flags", {bus.EQ, bus.GT, bus.LT}, 3'b000);
        end
    end

    always @(negedge clk) begin
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        n_tests = 0; n_fail = 0; rand_ready = 1'b0; err_cnt_m = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.A = '0; bus.B = '0;
        bus.signed_mode = 1'b0; bus.approx_mode = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", bus.in_ready, 32'd0);
        check_val("rst_out_valid", bus.out_valid, 32'd0);
        check_val("rst_flags", {bus.EQ, bus.GT, bus.LT}, 3'b000);
`ifdef CMP_ERR_MON_EN
        check_val("rst_err", bus.ERR, 32'd0);
        check_val("rst_err_count", bus.err_count, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Latency: exact unsigned, result 2 cycles after acceptance.
        send(32'h80000008, 32'h80008000, 1'b0, 1'b0);
        check_val("lat_not_early", bus.out_valid, 32'd0);
        @(posedge clk);
        #1;
        check_val("lat_valid", bus.out_valid, 32'd1);
        check_val("lat_lt", {bus.EQ, bus.GT, bus.LT}, 3'b001);
        drain();

        // Approx masking, then signed vs unsigned on the same operands back-to-back.
        send(32'h12345678, 32'h123456FF, 1'b0, 1'b1);
        send(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0);
        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        send(32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1);
        send(32'hFFFFFF00, 32'hFFFFFFFF, 1'b1, 1'b1);
        send(32'h00000000, 32'h00000000, 1'b1, 1'b0);
        drain();

        // Backpressure: fill both stages, in_ready must drop.
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(32'd1, 32'd2, 1'b0, 1'b0);
        send(32'd5, 32'd5, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        #1;
        check_val("bp_in_ready", bus.in_ready, 32'd0);
        check_val("bp_hold_valid", bus.out_valid, 32'd1);
        check_val("bp_hold_flags", {bus.EQ, bus.GT, bus.LT}, 3'b001);
        bus.in_valid = 1'b0;
        fork
            begin
                send(32'd9, 32'd3, 1'b0, 1'b0);
                send(32'hF0000000, 32'h10000000, 1'b1, 1'b0);
            end
            begin
                repeat (2) @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight.
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(32'h12345678, 32'h123456FF, 1'b0, 1'b1);
        send(32'h00000010, 32'h00000020, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q_exp.delete();
        err_cnt_m = 0;
        check_val("midrst_out_valid", bus.out_valid, 32'd0);
        check_val("midrst_in_ready", bus.in_ready, 32'd0);
`ifdef CMP_ERR_MON_EN
        check_val("midrst_err_count", bus.err_count, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("midrst_no_ghost", bus.out_valid, 32'd0);
        send(32'h00000003, 32'h00000002, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_val("postrst_lat", bus.out_valid, 32'd1);
        check_val("postrst_gt", {bus.EQ, bus.GT, bus.LT}, 3'b010);
        drain();

        // Random beats under random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = ra ^ 32'($urandom_range(0, 255));
                2: rb = ra ^ 32'($urandom_range(0, 65535));
                default: rb = ra;
            endcase
            send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        drain();

`ifdef CMP_ERR_MON_EN
        // Saturation of the mismatch counter.
        for (int i = 0; i < 65537; i++)
            send(32'h12345678, 32'h123456FF, 1'b0, 1'b1);
        drain();
        @(negedge clk);
        #2;
        check_val("sat_err_count", bus.err_count, 32'h0000FFFF);
        send(32'h00000001, 32'h000000FF, 1'b1, 1'b1);
        drain();
        @(negedge clk);
        #2;
        check_val("sat_hold", bus.err_count, 32'h0000FFFF);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/approx_comparator_pipe.md
APPROX_COMPARATOR_PIPE -- requirements
Module: approx_comparator_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits, multiple of CHUNK, minimum 8.
REQ-002 SHALL have parameter CHUNK, default 8: bits per first-stage sub-comparator.
REQ-003 SHALL have parameter APPROX_BITS, default 8: LSBs ignored in approximate mode, range 0..WIDTH-1.
REQ-004 SHALL have port clk  input  1: single clock, all state on the rising edge.
REQ-005 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1: operand beat offered.
REQ-007 SHALL have port in_ready  output  1: operand beat accepted when in_valid and in_ready are both high.
REQ-008 SHALL have ports A and B, each input, WIDTH bits: operands.
REQ-009 SHALL have port signed_mode  input  1: 1 selects two's-complement compare, 0 selects unsigned; sampled with the beat.
REQ-010 SHALL have port approx_mode  input  1: 1 masks the APPROX_BITS LSBs of both operands; sampled with the beat.
REQ-011 SHALL have port out_valid  output  1: result present.
REQ-012 SHALL have port out_ready  input  1: downstream consumes the result when out_valid and out_ready are both high.
REQ-013 SHALL have ports EQ, GT and LT, each output, 1 bit: result flags, registered.
REQ-014 SHALL have port ERR  output  1: approximate result differs from exact result (only with CMP_ERR_MON_EN).
REQ-015 SHALL have port err_count  output  16: saturating mismatch count (only with CMP_ERR_MON_EN).

Function
REQ-016 SHALL be a two-stage pipeline. Stage 1 registers per-chunk eq/gt vectors (WIDTH/CHUNK entries each) plus the mode bits. Stage 2 registers EQ/GT/LT by MSB-first priority over the chunks.
REQ-017 SHALL produce a result exactly 2 cycles after acceptance when out_ready is held high; throughput SHALL be 1 beat/cycle.
REQ-018 SHALL define a stage as able to load when it is empty or its contents leave in the same cycle; in_ready SHALL equal the stage-1 load condition, combinational from out_ready, with no combinational path from in_valid.
REQ-019 SHALL hold out_valid and EQ/GT/LT stable while out_valid=1 and out_ready=0; no beat SHALL be lost or duplicated.
REQ-020 SHALL assert exactly one of EQ, GT, LT whenever out_valid=1; all three SHALL be 0 when out_valid=0.
REQ-021 SHALL, with approx_mode=1, force the APPROX_BITS LSBs of both operands to 0 before the chunk compare; chunks wholly inside the mask SHALL therefore report equal. APPROX_BITS=0 SHALL make both modes identical.
REQ-022 SHALL, with signed_mode=1, treat the top chunk's MSB as the sign: if the signs differ, the positive operand is GT, regardless of the lower chunks. Masking SHALL apply only to LSBs, so signed approximate compare is valid.
REQ-023 SHALL let mode bits travel with their beat; a change of mode between beats SHALL NOT affect beats already in flight.

Reset
REQ-024 SHALL, while rst=1, clear both stage valid flags and set out_valid, EQ, GT, LT, ERR to 0 and err_count to 0; in_ready SHALL be 0 during reset.
REQ-025 SHALL discard in-flight beats on a reset mid-operation; the first beat accepted after rst falls SHALL appear 2 cycles later.

Configuration
REQ-026 SHALL, with macro CMP_ERR_MON_EN defined, additionally compute the exact, unmasked comparison in parallel and pipe it alongside the approximate one.
REQ-027 SHALL, with CMP_ERR_MON_EN defined, set ERR=1 with out_valid when approx_mode=1 and the approximate flags differ from the exact flags, and increment err_count on each consumed beat with ERR=1, saturating at 16'hFFFF.
REQ-028 SHALL, without CMP_ERR_MON_EN, omit the ERR and err_count ports and the exact path entirely.

Verification (WIDTH=32, CHUNK=8, APPROX_BITS=8)
REQ-029 Exact unsigned: A=32'h80000008, B=32'h80008000, both modes 0 -> 2 cycles later out_valid=1, LT=1.
REQ-030 Approx masking: A=32'h12345678, B=32'h123456FF, approx_mode=1 -> EQ=1; with CMP_ERR_MON_EN, ERR=1 and err_count increments 0->1.
REQ-031 Signed: A=32'hFFFFFFFF, B=32'h00000001, signed_mode=1 -> LT=1; the same beat with signed_mode=0 -> GT=1.
REQ-032 Backpressure: 4 back-to-back beats with out_ready=0 for 3 cycles -> in_ready falls once both stages are full, no beat lost, results emerge in order once out_ready=1.
REQ-033 Reset mid-flight: rst pulsed for 1 cycle with 2 beats in flight -> out_valid=0 next cycle, err_count=0, neither beat emerges.
REQ-034 Saturation (CMP_ERR_MON_EN): 65537 consumed mismatching approx beats -> err_count=16'hFFFF and held there.
